regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the pipelined core.
- Successor to the single-write, two-read, negedge-write register file: adds configurable width/depth/read-port count, a second write port, posedge writes with optional same-cycle bypass, asynchronous reset, and per-register busy (scoreboard) bits.
- Sits between decode (reads, busy check, issue) and writeback (ALU port 0, load-return port 1).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  scoreboard busy bit for each read address
- wr0_en  in  1  write port 0 enable (ALU writeback)
- wr0_addr  in  ADDR_W  write port 0 address
- wr0_data  in  DATA_W  write port 0 data
- wr1_en  in  1  write port 1 enable (load return)
- wr1_addr  in  ADDR_W  write port 1 address
- wr1_data  in  DATA_W  write port 1 data
- iss_en  in  1  mark destination busy (instruction issued)
- iss_addr  in  ADDR_W  destination being marked
- flush  in  1  synchronous clear of all busy bits

Behaviour:
- Reset (rst_n=0, asynchronous): all registers 0, all busy bits 0. rd_data and rd_busy then follow combinationally from the cleared state. Release is synchronous to clk.
- Register 0: reads always return 0, busy always 0. Writes and issues to address 0 are ignored.
- Write: on posedge, if wrN_en and wrN_addr != 0, reg[wrN_addr] <= wrN_data.
- Both write ports to the same address in the same cycle: port 1 wins.
- Read: combinational from array, zero latency.
- Busy set: on posedge, iss_en with iss_addr != 0 sets busy[iss_addr].
- Busy clear: on posedge, a write on either port clears busy[wr_addr].
- Set and clear of the same register in the same cycle: set wins (new producer).
- flush: clears all busy bits; any same-cycle iss_en is still applied after the clear. flush does not touch register contents.
- Reset asserted mid-operation discards pending writes and issues in that cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read port whose address matches an enabled, nonzero write address in the same cycle returns that write data; port 1 has priority over port 0.
  - rd_busy for that port returns 0, unless iss_en targets the same address that cycle, in which case it returns 1.
- Undefined:
  - rd_data and rd_busy come purely from stored state.
  - A written value and its busy clear become visible the cycle after the write edge.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after writing 0xDEADBEEF to x5 -> rd_data for x5 is 0 immediately, before any clock edge; all rd_busy=0.
- x0 protection: wr0 writes 0x12345678 to address 0 with iss_en to address 0 -> read x0 returns 0, rd_busy=0.
- Dual write, same address: wr0 (x7, 0x11) and wr1 (x7, 0x22) in one cycle -> next cycle x7 reads 0x22.
- Scoreboard: issue x3, then wr1 x3=0xA5 three cycles later -> rd_busy(x3)=1 for the intervening cycles, 0 afterwards; simultaneous iss_en x3 with a write to x3 -> busy stays 1.
- Flush: busy set on x1, x2, x9, then flush together with iss_en x4 -> only x4 busy next cycle.
- Bypass (macro defined): read x6 while wr0 writes 0xCAFEF00D to x6 -> same-cycle rd_data=0xCAFEF00D. Macro undefined -> old value that cycle, new value next cycle. Run with NUM_RD=4, DATA_W=64.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with two posedge write
// ports (port 1 = load return, wins on address collision), NUM_RD
// combinational read ports and per-register busy (scoreboard) bits.
// Register 0 is hard-wired to zero and is never marked busy.
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> reads see same-cycle write data (port 1 over port 0) and the
//                matching busy clear, unless a same-cycle issue re-marks it.
//   undefined -> reads come purely from stored state.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;

  logic wr0_ok;
  logic wr1_ok;
  logic iss_ok;

  // Accesses to address 0 are dropped so x0 stays zero and never busy.
  assign wr0_ok = wr0_en && (wr0_addr != '0);
  assign wr1_ok = wr1_en && (wr1_addr != '0);
  assign iss_ok = iss_en && (iss_addr != '0);

  // Next busy vector: flush first, then write clears, then issue set (set wins).
  always_comb begin
    busy_next = flush ? '0 : busy;
    if (wr0_ok) busy_next[wr0_addr] = 1'b0;
    if (wr1_ok) busy_next[wr1_addr] = 1'b0;
    if (iss_ok) busy_next[iss_addr] = 1'b1;
  end

  // Register array: port 1 is applied after port 0 so it wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr0_ok) regs[wr0_addr] <= wr0_data;
      if (wr1_ok) regs[wr1_addr] <= wr1_data;
    end
  end

  // Scoreboard busy bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    logic              rb;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    // Read port k: stored state, optionally overridden by same-cycle writes.
    always_comb begin
      rdat = regs[ra];
      rb   = busy[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr1_ok && (wr1_addr == ra)) begin
        rdat = wr1_data;
        rb   = iss_ok && (iss_addr == ra);
      end else if (wr0_ok && (wr0_addr == ra)) begin
        rdat = wr0_data;
        rb   = iss_ok && (iss_addr == ra);
      end
`endif
      if (ra == '0) begin
        rdat = '0;
        rb   = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = rdat;
    assign rd_busy[k]                  = rb;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp (NUM_RD=4, DATA_W=64).
// Expected read results come from a small reference model and are queued
// when stimulus is driven, then popped and compared against the read ports.
module tb_regfile_mp;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 4;
  localparam int DEPTH  = 32;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr0_en, wr1_en, iss_en, flush;
  logic [ADDR_W-1:0]        wr0_addr, wr1_addr, iss_addr;
  logic [DATA_W-1:0]        wr0_data, wr1_data;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
  );

  typedef struct {
    int               port;
    bit               isBusy;
    logic [DATA_W-1:0] exp;
  } expT;

  expT               sbQ[$];
  logic [DATA_W-1:0] mReg [DEPTH];
  bit                mBusy [DEPTH];
  int                checks = 0;
  int                errors = 0;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [ADDR_W-1:0] portAddr(input int p);
    return rd_addr[p*ADDR_W +: ADDR_W];
  endfunction

  // Expected combinational read value given the model and current inputs.
  function automatic logic [DATA_W-1:0] expData(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (rst_n && wr1_en && wr1_addr == a) return wr1_data;
    if (rst_n && wr0_en && wr0_addr == a) return wr0_data;
`endif
    return mReg[a];
  endfunction

  function automatic bit expBusy(input logic [ADDR_W-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (rst_n && ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a)))
      return iss_en && iss_addr == a;
`endif
    return mBusy[a];
  endfunction

  task automatic pushExpected();
    for (int p = 0; p < NUM_RD; p++) begin
      sbQ.push_back('{port: p, isBusy: 1'b0, exp: expData(portAddr(p))});
      sbQ.push_back('{port: p, isBusy: 1'b1, exp: {{(DATA_W-1){1'b0}}, expBusy(portAddr(p))}});
    end
  endtask

  task automatic drainScoreboard(input string tag);
    expT e;
    logic [DATA_W-1:0] obs;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      obs = e.isBusy ? {{(DATA_W-1){1'b0}}, rd_busy[e.port]} : rd_data[e.port*DATA_W +: DATA_W];
      checkOutput($sformatf("%s p%0d %s", tag, e.port, e.isBusy ? "busy" : "data"), obs, e.exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) begin
      mReg[i]  = '0;
      mBusy[i] = 1'b0;
    end
  endtask

  // Model state update at the clock edge using the inputs held this cycle.
  task automatic updateModel();
    bit nb [DEPTH];
    for (int i = 0; i < DEPTH; i++) nb[i] = flush ? 1'b0 : mBusy[i];
    if (wr0_en && wr0_addr != 0) begin mReg[wr0_addr] = wr0_data; nb[wr0_addr] = 1'b0; end
    if (wr1_en && wr1_addr != 0) begin mReg[wr1_addr] = wr1_data; nb[wr1_addr] = 1'b0; end
    if (iss_en && iss_addr != 0) nb[iss_addr] = 1'b1;
    for (int i = 0; i < DEPTH; i++) mBusy[i] = nb[i];
  endtask

  task automatic setRead(input int a0, input int a1, input int a2, input int a3);
    rd_addr = {ADDR_W'(a3), ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  // One clock cycle: drive at negedge, check reads, advance model at posedge.
  task automatic applyStimulus(input string tag,
                               input bit w0e, input int w0a, input logic [DATA_W-1:0] w0d,
                               input bit w1e, input int w1a, input logic [DATA_W-1:0] w1d,
                               input bit ie, input int ia, input bit fl);
    @(negedge clk);
    wr0_en = w0e; wr0_addr = ADDR_W'(w0a); wr0_data = w0d;
    wr1_en = w1e; wr1_addr = ADDR_W'(w1a); wr1_data = w1d;
    iss_en = ie;  iss_addr = ADDR_W'(ia);  flush = fl;
    pushExpected();
    #1 drainScoreboard(tag);
    @(posedge clk);
    updateModel();
    #1;
    wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 0, 0, '0, 0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    wr0_en = 0; wr1_en = 0; iss_en = 0; flush = 0;
    wr0_addr = '0; wr1_addr = '0; iss_addr = '0;
    wr0_data = '0; wr1_data = '0;
    setRead(0, 5, 7, 31);
    clearModel();
    #2;
    pushExpected();
    #1 drainScoreboard("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Write x5 and mark x8 busy, then reset mid-cycle.
    setRead(5, 8, 0, 3);
    applyStimulus("pre_rst", 1, 5, 64'hDEADBEEF, 0, 0, '0, 1, 8, 0);
    idle("pre_rst_idle");
    checkOutput("x5 before reset", rd_data[0 +: DATA_W], 64'hDEADBEEF);
    checkOutput("x8 busy before reset", {63'd0, rd_busy[1]}, 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    clearModel();
    #1;
    checkOutput("x5 async reset", rd_data[0 +: DATA_W], 64'd0);
    checkOutput("busy async reset", {60'd0, rd_busy}, 64'd0);
    pushExpected();
    drainScoreboard("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // x0 protection.
    setRead(0, 0, 1, 2);
    applyStimulus("x0_wr", 1, 0, 64'h12345678, 0, 0, '0, 1, 0, 0);
    idle("x0_after");
    checkOutput("x0 data", rd_data[0 +: DATA_W], 64'd0);
    checkOutput("x0 busy", {63'd0, rd_busy[0]}, 64'd0);

    // Dual write collision: port 1 wins.
    setRead(7, 0, 0, 0);
    applyStimulus("dual_wr", 1, 7, 64'h11, 1, 7, 64'h22, 0, 0, 0);
    idle("dual_after");
    checkOutput("x7 dual write", rd_data[0 +: DATA_W], 64'h22);

    // Scoreboard: issue x3, write back three cycles later.
    setRead(3, 0, 0, 0);
    applyStimulus("iss_x3", 0, 0, '0, 0, 0, '0, 1, 3, 0);
    idle("x3_wait1");
    checkOutput("x3 busy wait", {63'd0, rd_busy[0]}, 64'd1);
    idle("x3_wait2");
    applyStimulus("wb_x3", 0, 0, '0, 1, 3, 64'hA5, 0, 0, 0);
    idle("x3_done");
    checkOutput("x3 busy cleared", {63'd0, rd_busy[0]}, 64'd0);
    checkOutput("x3 data", rd_data[0 +: DATA_W], 64'hA5);
    applyStimulus("x3_set_clr", 1, 3, 64'h5A, 0, 0, '0, 1, 3, 0);
    idle("x3_set_wins");
    checkOutput("x3 set wins", {63'd0, rd_busy[0]}, 64'd1);

    // Flush with a same-cycle issue.
    setRead(1, 2, 9, 4);
    applyStimulus("iss_x1", 0, 0, '0, 0, 0, '0, 1, 1, 0);
    applyStimulus("iss_x2", 0, 0, '0, 0, 0, '0, 1, 2, 0);
    applyStimulus("iss_x9", 0, 0, '0, 0, 0, '0, 1, 9, 0);
    applyStimulus("flush", 0, 0, '0, 0, 0, '0, 1, 4, 1);
    idle("flush_after");
    checkOutput("flush busy vec", {60'd0, rd_busy}, 64'h8);

    // Same-cycle read of a register being written.
    setRead(6, 6, 0, 0);
    applyStimulus("x6_old", 1, 6, 64'h1111, 0, 0, '0, 0, 0, 0);
    @(negedge clk);
    wr0_en = 1'b1; wr0_addr = 5'd6; wr0_data = 64'hCAFEF00D;
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("x6 bypass", rd_data[0 +: DATA_W], 64'hCAFEF00D);
`else
    checkOutput("x6 no bypass", rd_data[0 +: DATA_W], 64'h1111);
`endif
    @(posedge clk);
    updateModel();
    #1 wr0_en = 1'b0;
    idle("x6_after");
    checkOutput("x6 next cycle", rd_data[0 +: DATA_W], 64'hCAFEF00D);

    // Random traffic against the model.
    for (int n = 0; n < 80; n++) begin
      setRead($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      applyStimulus($sformatf("rand%0d", n),
                    bit'($urandom_range(0, 1)), $urandom_range(0, 31), {$urandom, $urandom},
                    bit'($urandom_range(0, 1)), $urandom_range(0, 31), {$urandom, $urandom},
                    bit'($urandom_range(0, 1)), $urandom_range(0, 31),
                    $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
